// File: rtl/pipe_memory_access_if.sv
// Core data bus between the memory-access stage (master) and the data memory (slave).
// One word-aligned transfer completes on the edge where memReq && memAck.
interface pipe_memory_access_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteSel;
  logic [31:0] memWData;
  logic        memAck;
  logic [31:0] memRData;

  modport master (
    output memReq, memWe, memAddr, memByteSel, memWData,
    input  memAck, memRData
  );

  modport slave (
    input  memReq, memWe, memAddr, memByteSel, memWData,
    output memAck, memRData
  );
endinterface

// File: rtl/pipe_memory_access.sv
// Memory-access pipe stage: issues one word-aligned bus transfer per load/store,
// stalls until ack or timeout, then holds the raw read word and fault flags for writeback.
module pipe_memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stepPipe,
  input  logic                        accessStart,
  input  logic                        isStore,
  input  logic [2:0]                  funct3,
  input  logic [31:0]                 address,
  input  logic [31:0]                 storeData,
  output logic                        accessStall,
  output logic [31:0]                 loadData,
  output logic                        faultMisaligned,
  output logic                        faultTimeout,
  pipe_memory_access_if.master        mem
);

  localparam int unsigned CNT_W      = 8;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      load_data_q;
  logic             fault_mis_q;
  logic             fault_to_q;

  logic [3:0]  base_mask_d;
  logic        size_ok_d;
  logic [6:0]  mask7_d;
  logic        misaligned_d;
  logic [31:0] wdata_d;
  logic        unused_funct3;

  // Sign/zero variant (funct3[2]) only matters to the downstream extender.
  assign unused_funct3 = funct3[2];

  // Lane mask and replicated write data from the access size and byte offset.
  always_comb begin
    base_mask_d = 4'b0000;
    size_ok_d   = 1'b1;
    wdata_d     = storeData;
    case (funct3[1:0])
      2'b00: begin
        base_mask_d = 4'b0001;
        wdata_d     = {4{storeData[7:0]}};
      end
      2'b01: begin
        base_mask_d = 4'b0011;
        wdata_d     = {2{storeData[15:0]}};
      end
      2'b10: base_mask_d = 4'b1111;
      default: size_ok_d = 1'b0;
    endcase
    mask7_d      = 7'({3'b000, base_mask_d} << address[1:0]);
    misaligned_d = !size_ok_d || (|mask7_d[6:4]);
  end

  // Gated by rst so the stall drops with the asynchronous reset as well.
  assign accessStall = !rst && (((state_q == IDLE) && accessStart) || (state_q == REQUEST));

  assign loadData        = load_data_q;
  assign faultMisaligned = fault_mis_q;
  assign faultTimeout    = fault_to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      load_data_q    <= '0;
      fault_mis_q    <= 1'b0;
      fault_to_q     <= 1'b0;
      mem.memReq     <= 1'b0;
      mem.memWe      <= 1'b0;
      mem.memAddr    <= '0;
      mem.memByteSel <= '0;
      mem.memWData   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accessStart) begin
            if (misaligned_d) begin
              fault_mis_q <= 1'b1;
              load_data_q <= '0;
              state_q     <= DONE;
            end else begin
              mem.memAddr    <= {address[31:2], 2'b00};
              mem.memByteSel <= mask7_d[3:0];
              mem.memWData   <= wdata_d;
              mem.memWe      <= isStore;
              mem.memReq     <= 1'b1;
              cnt_q          <= '0;
              state_q        <= REQUEST;
            end
          end
        end
        REQUEST: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (mem.memAck) begin
            load_data_q <= mem.memWe ? 32'h0 : mem.memRData;
            mem.memReq  <= 1'b0;
            state_q     <= DONE;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            fault_to_q  <= 1'b1;
            load_data_q <= '0;
            mem.memReq  <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (stepPipe) begin
            fault_mis_q <= 1'b0;
            fault_to_q  <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_memory_access.sv
// Directed bench for pipe_memory_access: table of single accesses plus
// hand-written reset-mid-request and back-to-back sequences.
module tb_pipe_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stepPipe = 1'b0;
  logic        accessStart = 1'b0;
  logic        isStore = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = '0;
  logic [31:0] storeData = '0;
  logic        accessStall;
  logic [31:0] loadData;
  logic        faultMisaligned;
  logic        faultTimeout;

  int total = 0;
  int bad   = 0;

  pipe_memory_access_if bus();

  pipe_memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .stepPipe        (stepPipe),
    .accessStart     (accessStart),
    .isStore         (isStore),
    .funct3          (funct3),
    .address         (address),
    .storeData       (storeData),
    .accessStall     (accessStall),
    .loadData        (loadData),
    .faultMisaligned (faultMisaligned),
    .faultTimeout    (faultTimeout),
    .mem             (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_at;   // REQUEST cycle carrying the ack, 0 = never
    logic [31:0] e_addr;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
    logic        e_mis;
    logic        e_to;
    int          e_stall;
    int          e_req;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_pipe();
    @(negedge clk);
    stepPipe = 1'b1;
    @(posedge clk);
    #1;
    stepPipe = 1'b0;
    chk("step_fault_mis", 72'(faultMisaligned), 72'(0));
    chk("step_fault_to", 72'(faultTimeout), 72'(0));
    chk("step_idle_stall", 72'(accessStall), 72'(0));
  endtask

  task automatic run(input vec_t v, input bit do_step);
    int stall = 0;
    int req   = 0;
    int guard = 0;
    logic [68:0] snap = '0;
    @(negedge clk);
    accessStart = 1'b1;
    isStore     = v.st;
    funct3      = v.f3;
    address     = v.addr;
    storeData   = v.sd;
    bus.memAck  = 1'b0;
    #1;
    while (accessStall && guard < 40) begin
      guard++;
      stall++;
      if (bus.memReq) begin
        req++;
        if (req == 1) begin
          snap = {bus.memAddr, bus.memByteSel, bus.memWe, bus.memWData};
          chk("mem_addr", 72'(bus.memAddr), 72'(v.e_addr));
          chk("mem_sel", 72'(bus.memByteSel), 72'(v.e_sel));
          chk("mem_we", 72'(bus.memWe), 72'(v.st));
          chk("mem_wdata", 72'(bus.memWData), 72'(v.e_wdata));
        end else begin
          chk("bus_hold", 72'({bus.memAddr, bus.memByteSel, bus.memWe, bus.memWData}), 72'(snap));
        end
        bus.memAck   = (req == v.ack_at);
        bus.memRData = v.rdata;
      end
      @(posedge clk);
      #1;
      accessStart  = 1'b0;
      bus.memAck   = 1'b0;
      bus.memRData = '0;
    end
    if (guard >= 40) chk("no_hang", 72'(guard), 72'(0));
    chk("stall_cycles", 72'(stall), 72'(v.e_stall));
    chk("req_cycles", 72'(req), 72'(v.e_req));
    chk("done_req_low", 72'(bus.memReq), 72'(0));
    chk("load_data", 72'(loadData), 72'(v.e_load));
    chk("fault_mis", 72'(faultMisaligned), 72'(v.e_mis));
    chk("fault_to", 72'(faultTimeout), 72'(v.e_to));
    if (do_step) step_pipe();
  endtask

  initial begin
    bus.memAck   = 1'b0;
    bus.memRData = '0;

    //            st  f3      addr          sd            rdata         ack e_addr        e_sel    e_wdata       e_load        mis to stall req
    vecs[0] = '{1'b0, 3'b010, 32'h0000_1000, 32'h1234_5678, 32'hDEAD_BEEF, 3, 32'h0000_1000, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 3};
    vecs[1] = '{1'b0, 3'b001, 32'h0000_3003, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0};
    vecs[2] = '{1'b1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h9999_9999, 1, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         1'b0, 1'b0, 2, 1};
    vecs[3] = '{1'b0, 3'b011, 32'h0000_4000, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0};
    vecs[4] = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,         32'h7777_7777, 0, 32'h0000_5000, 4'b1111, 32'h0,         32'h0,         1'b0, 1'b1, 5, 4};
    vecs[5] = '{1'b0, 3'b010, 32'h0000_5004, 32'h0,         32'hCAFE_F00D, 4, 32'h0000_5004, 4'b1111, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 5, 4};
    vecs[6] = '{1'b1, 3'b001, 32'h0000_6002, 32'h1234_BEEF, 32'h0,         2, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0, 1'b0, 3, 2};
    vecs[7] = '{1'b0, 3'b101, 32'h0000_6001, 32'h0,         32'h1122_3344, 1, 32'h0000_6000, 4'b0110, 32'h0,         32'h1122_3344, 1'b0, 1'b0, 2, 1};
    vecs[8] = '{1'b0, 3'b010, 32'h0000_7002, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0};
    vecs[9] = '{1'b0, 3'b100, 32'h0000_7002, 32'h0000_00C3, 32'h5566_7788, 1, 32'h0000_7000, 4'b0100, 32'hC3C3_C3C3, 32'h5566_7788, 1'b0, 1'b0, 2, 1};

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 72'(bus.memReq), 72'(0));
    chk("rst_we", 72'(bus.memWe), 72'(0));
    chk("rst_bus", 72'({bus.memAddr, bus.memByteSel, bus.memWData}), 72'(0));
    chk("rst_load", 72'(loadData), 72'(0));
    chk("rst_faults", 72'({faultMisaligned, faultTimeout}), 72'(0));
    chk("rst_stall", 72'(accessStall), 72'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run(vecs[i], 1'b1);

    // Reset two cycles into REQUEST: outputs drop without a clock edge
    @(negedge clk);
    accessStart = 1'b1;
    isStore     = 1'b0;
    funct3      = 3'b010;
    address     = 32'h0000_8000;
    @(posedge clk);
    #1;
    accessStart = 1'b0;
    chk("pre_rst_req", 72'(bus.memReq), 72'(1));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 72'(bus.memReq), 72'(0));
    chk("async_rst_stall", 72'(accessStall), 72'(0));
    chk("async_rst_load", 72'(loadData), 72'(0));
    @(negedge clk);
    rst = 1'b0;
    run(vecs[0], 1'b1);

    // Back-to-back: step out of a timed-out access with a new load already requested
    run(vecs[4], 1'b0);
    @(negedge clk);
    stepPipe    = 1'b1;
    accessStart = 1'b1;
    isStore     = 1'b0;
    funct3      = 3'b010;
    address     = 32'h0000_1004;
    @(posedge clk);
    #1;
    stepPipe = 1'b0;
    chk("b2b_fault_cleared", 72'(faultTimeout), 72'(0));
    chk("b2b_idle_req", 72'(bus.memReq), 72'(0));
    chk("b2b_idle_stall", 72'(accessStall), 72'(1));
    @(posedge clk);
    #1;
    accessStart = 1'b0;
    chk("b2b_req", 72'(bus.memReq), 72'(1));
    chk("b2b_addr", 72'(bus.memAddr), 72'(32'h0000_1004));
    bus.memAck   = 1'b1;
    bus.memRData = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.memAck   = 1'b0;
    bus.memRData = '0;
    chk("b2b_stall", 72'(accessStall), 72'(0));
    chk("b2b_load", 72'(loadData), 72'(32'h0BAD_F00D));
    chk("b2b_faults", 72'({faultMisaligned, faultTimeout}), 72'(0));
    step_pipe();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_memory_access.md
# pipe_memory_access

Memory-access stage of the core pipeline, between execute and store (writeback). It takes a load/store request (address from the ALU result, funct3, store data) and issues one word-aligned transaction on the core data bus. It stalls the pipe until the bus acknowledges, then holds the raw 32-bit read word and fault flags stable for the store stage until the pipe steps. Byte-lane extraction and sign extension of loads are done downstream, not here.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles waiting for memAck before a timeout fault; 0 disables the timeout. Range 0-255.

Ports:
- clk  input  1  core clock; one clock domain.
- rst  input  1  asynchronous, active-high reset.
- stepPipe  input  1  pipe advance strobe.
- accessStart  input  1  current instruction is a load or store and is valid.
- isStore  input  1  1 = store, 0 = load.
- funct3  input  3  RISC-V load/store funct3.
- address  input  32  effective address (ALU result).
- storeData  input  32  rs2 value.
- accessStall  output  1  request pipe stall.
- loadData  output  32  captured raw bus read word.
- faultMisaligned  output  1  access crossed a word boundary or had an invalid size.
- faultTimeout  output  1  bus did not acknowledge in time.
- memReq  output  1  bus request.
- memWe  output  1  write enable, valid with memReq.
- memAddr  output  32  word address, bits [1:0] = 0.
- memByteSel  output  4  active byte lanes.
- memWData  output  32  write data, lane-replicated.
- memAck  input  1  bus acknowledge; completes the transfer on the edge where memReq && memAck.
- memRData  input  32  read data, valid with memAck.

## Operation
- FSM states: IDLE, REQUEST, DONE.
- Base mask from funct3[1:0]:
  - 00 → 0001
  - 01 → 0011
  - 10 → 1111
  - 11 → invalid (misaligned fault)
- mask7 = {3'b0, base} << address[1:0]. Misaligned = |mask7[6:4], or size invalid.
- memByteSel = mask7[3:0].
- memWData by size:
  - byte: {4{storeData[7:0]}}
  - half: {2{storeData[15:0]}}
  - word: storeData
- IDLE with accessStart:
  - Misaligned: go to DONE with faultMisaligned=1 and loadData=0. No bus cycle.
  - Otherwise: register memAddr/memByteSel/memWData/memWe and go to REQUEST. Clear the timeout counter.
- REQUEST: memReq=1.
  - On memReq && memAck: loadData ← memRData for loads, or 0 for stores. Go to DONE.
  - Else, with TIMEOUT_CYCLES≠0 and counter = TIMEOUT_CYCLES-1: go to DONE with faultTimeout=1 and loadData=0.
  - Otherwise the counter increments.
- DONE: outputs held. On stepPipe go to IDLE and clear both fault flags. A new accessStart is only sampled in IDLE.
- Ack and timeout on the same edge: ack wins, no fault.
- memAck outside REQUEST is ignored.
- Bus outputs are held constant for the whole of REQUEST.
- stepPipe in IDLE or REQUEST has no effect on this block; the stall prevents it upstream.

## Timing
- Reset values: all outputs 0 and state IDLE. Reset asserted mid-REQUEST drops memReq immediately (asynchronously) and discards the transfer.
- accessStall = (IDLE && accessStart) || REQUEST. It is combinational and deasserts in DONE.
- Aligned access:
  - accessStart seen in cycle N; memReq high from cycle N+1.
  - Ack in cycle N+k captures data at the end of that cycle.
  - DONE, with stall low and loadData valid, from cycle N+k+1.
  - Minimum stall is 2 cycles (k=1).
- Misaligned access: 1 stall cycle; DONE from cycle N+1.
- Timeout: memReq is high for exactly TIMEOUT_CYCLES cycles, then DONE.
- loadData and the fault flags are stable from DONE entry until the cycle after stepPipe.

## Test plan
- Word load: address=0x1000, funct3=010, ack on the 3rd REQUEST cycle with memRData=0xDEADBEEF.
  → memAddr=0x1000, memByteSel=1111, memWe=0; stall for 4 cycles; loadData=0xDEADBEEF in DONE; no faults.
- Byte store: address=0x2003, funct3=000, storeData=0x000000A5, immediate ack.
  → memAddr=0x2000, memByteSel=1000, memWData=0xA5A5A5A5, memWe=1; loadData=0.
- Misaligned half: address=0x3003, funct3=001.
  → no memReq ever; faultMisaligned=1 after 1 stall cycle. funct3=011 also faults.
- Timeout: TIMEOUT_CYCLES=4, memAck held 0.
  → memReq high exactly 4 cycles; faultTimeout=1 and loadData=0. Ack on the 4th cycle instead gives no fault.
- Reset mid-REQUEST: assert rst 2 cycles into REQUEST.
  → memReq, accessStall and loadData are 0 without waiting for a clock edge. The next access works normally.
- Back-to-back: stepPipe in DONE, with accessStart held for a new load at 0x1004.
  → one IDLE cycle, then a new REQUEST; faults from the prior access cleared.
